usb_tx_param: RTL and testbench

Parametrised USB full-speed packet transmitter. Serialises handshake (ACK/NAK/STALL) and data (DATA0/DATA1) packets onto the D+/D− lines: SYNC, PID, payload pulled from the TX FIFO, CRC16, then EOP. Applies bit stuffing and NRZI encoding. Sits between the endpoint TX FIFO and the bus driver, and supersedes the fixed-rate transmitter with configurable bit rate, a payload limit and error reporting.

---
 rtl/usb_tx_param.sv | 259 +++++++++++++++++++++++++
 tb/tb_usb_tx_param.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_param.sv
// USB full-speed packet transmitter: SYNC, PID, FIFO payload, optional CRC16, EOP with bit stuffing and NRZI.
// Latency: first SYNC bit on the lines one cycle after tx_start; each bit lasts CLKS_PER_BIT cycles.
// Backpressure: pulls payload bytes with a one-cycle pop at byte boundaries; tx_start is ignored while busy.
// Optional feature macro: USB_TX_CRC16_EN (defined = CRC16 generated here; undefined = FIFO supplies CRC bytes).
module usb_tx_param #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_PAYLOAD  = 64,
    parameter int OCC_W        = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [2:0]       tx_packet,
    input  logic [7:0]       tx_packet_data,
    input  logic [OCC_W-1:0] buffer_occupancy,
    output logic             get_tx_packet_data,
    output logic             tx_transfer_active,
    output logic             tx_error,
    output logic             dplus_out,
    output logic             dminus_out
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BC_W  = $clog2(MAX_PAYLOAD + 1);
    localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BC_W-1:0]  MAX_BC   = BC_W'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP_SE0, S_EOP_J
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [15:0]      r_shift;      // field being sent, bit on the wire sits at [0]
    logic [3:0]       r_bit_idx;    // index of the bit on the wire within its field
    logic [2:0]       r_ones;       // consecutive ones launched, drives stuffing
    logic             r_lvl;        // NRZI level, 1 = J
    logic [7:0]       r_pid;
    logic             r_handshake;
    logic [BC_W-1:0]  r_byte_cnt;
    logic             r_active;
    logic             r_err;
    logic             r_dplus;
    logic             r_dminus;
`ifdef USB_TX_CRC16_EN
    logic [15:0]      r_crc;        // reflected CRC16 register (poly 0x8005 bit-reversed)
    logic             w_crc_bit;
    logic             w_crc_fb;
    logic [15:0]      w_crc_nxt;
`endif

    logic       w_code_ok;
    logic [3:0] w_pid4;
    logic       w_bit_end;
    logic       w_stream;
    logic       w_field_last;
    logic       w_adv;
    logic       w_fend;
    logic       w_payload_bnd;
    logic       w_have;
    logic       w_room;
    logic       w_pop_ok;
    logic       w_launch;
    logic       w_bit;
    logic       w_lvl_nxt;

    function automatic logic [3:0] pid_of(input logic [2:0] code);
        case (code)
            3'd1:    return 4'b0011;
            3'd2:    return 4'b1011;
            3'd3:    return 4'b0010;
            3'd4:    return 4'b1010;
            3'd5:    return 4'b1110;
            default: return 4'b0000;
        endcase
    endfunction

    assign w_code_ok     = (tx_packet != 3'd0) && (tx_packet < 3'd6);
    assign w_pid4        = pid_of(tx_packet);
    assign w_bit_end     = (r_state != S_IDLE) && (r_clk_cnt == LAST_CLK);
    assign w_stream      = (r_state == S_SYNC) || (r_state == S_PID) ||
                           (r_state == S_DATA) || (r_state == S_CRC);
    assign w_field_last  = (r_bit_idx == ((r_state == S_CRC) ? 4'd15 : 4'd7));
    // A real field bit finishes (not a stuffed one that still has to be inserted)
    assign w_adv         = w_bit_end && w_stream && (r_ones != 3'd6);
    assign w_fend        = w_adv && w_field_last;
    assign w_payload_bnd = (r_state == S_DATA) || ((r_state == S_PID) && !r_handshake);
    assign w_have        = (buffer_occupancy != '0);
    assign w_room        = (r_byte_cnt < MAX_BC);
    assign w_pop_ok      = w_fend && w_payload_bnd && w_have && w_room;

    // The pop must coincide with the cycle the head byte is captured, so it is decoded, not registered
    assign get_tx_packet_data = w_pop_ok && !rst;
    assign tx_transfer_active = r_active;
    assign tx_error           = r_err;
    assign dplus_out          = r_dplus;
    assign dminus_out         = r_dminus;

`ifdef USB_TX_CRC16_EN
    assign w_crc_fb  = w_bit ^ r_crc[0];
    assign w_crc_nxt = {1'b0, r_crc[15:1]} ^ (w_crc_fb ? 16'hA001 : 16'h0000);
`endif

    // Pick the next data bit to put on the wire at a bit-time boundary (or at packet start)
    always_comb begin
        w_launch = 1'b0;
        w_bit    = 1'b0;
`ifdef USB_TX_CRC16_EN
        w_crc_bit = 1'b0;
`endif
        if (r_state == S_IDLE) begin
            w_launch = tx_start && w_code_ok;   // SYNC bit 0 is a 0
        end else if (w_bit_end && w_stream) begin
            w_launch = 1'b1;
            if (r_ones == 3'd6) begin
                w_bit = 1'b0;                   // stuffed bit
            end else if (!w_field_last) begin
                w_bit = r_shift[1];
`ifdef USB_TX_CRC16_EN
                w_crc_bit = (r_state == S_DATA);
`endif
            end else begin
                case (r_state)
                    S_SYNC: w_bit = r_pid[0];
                    S_PID, S_DATA: begin
                        if (w_pop_ok) begin
                            w_bit = tx_packet_data[0];
`ifdef USB_TX_CRC16_EN
                            w_crc_bit = 1'b1;
                        end else if (w_payload_bnd && !w_have) begin
                            w_bit = ~r_crc[0];
`endif
                        end else begin
                            w_launch = 1'b0;
                        end
                    end
                    default: w_launch = 1'b0;
                endcase
            end
        end
    end

    assign w_lvl_nxt = w_bit ? r_lvl : ~r_lvl;

`ifdef USB_TX_CRC16_EN
    // CRC accumulates payload bits as they are launched; stuffed bits never enter it
    always_ff @(posedge clk) begin
        if (rst || (r_state == S_IDLE)) begin
            r_crc <= 16'hFFFF;
        end else if (w_launch && w_crc_bit) begin
            r_crc <= w_crc_nxt;
        end
    end
`endif

    // Packet sequencer: bit timing, field shifting, stuffing/NRZI state and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_clk_cnt   <= '0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_ones      <= '0;
            r_lvl       <= 1'b1;
            r_pid       <= '0;
            r_handshake <= 1'b0;
            r_byte_cnt  <= '0;
            r_active    <= 1'b0;
            r_err       <= 1'b0;
            r_dplus     <= 1'b1;
            r_dminus    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_launch) begin
                r_lvl    <= w_lvl_nxt;
                r_dplus  <= w_lvl_nxt;
                r_dminus <= ~w_lvl_nxt;
                r_ones   <= w_bit ? (r_ones + 3'd1) : 3'd0;
            end
            if (r_state != S_IDLE) begin
                r_clk_cnt <= w_bit_end ? '0 : (r_clk_cnt + 1'b1);
            end
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    if (tx_start && w_code_ok) begin
                        r_state     <= S_SYNC;
                        r_pid       <= {~w_pid4, w_pid4};
                        r_handshake <= (tx_packet >= 3'd3);
                        r_shift     <= 16'h0080;
                        r_bit_idx   <= '0;
                        r_byte_cnt  <= '0;
                        r_active    <= 1'b1;
                    end else begin
                        r_lvl  <= 1'b1;
                        r_ones <= '0;
                        r_err  <= tx_start;
                    end
                end
                S_SYNC, S_PID, S_DATA, S_CRC: begin
                    if (w_adv && !w_field_last) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end else if (w_fend) begin
                        r_bit_idx <= '0;
                        if (r_state == S_SYNC) begin
                            r_state <= S_PID;
                            r_shift <= {8'h00, r_pid};
                        end else if ((r_state == S_CRC) || !w_payload_bnd) begin
                            r_state  <= S_EOP_SE0;
                            r_dplus  <= 1'b0;
                            r_dminus <= 1'b0;
                        end else if (w_pop_ok) begin
                            r_state    <= S_DATA;
                            r_shift    <= {8'h00, tx_packet_data};
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end else if (w_have) begin
                            // payload limit hit with bytes still queued: abort without CRC
                            r_err    <= 1'b1;
                            r_state  <= S_EOP_SE0;
                            r_dplus  <= 1'b0;
                            r_dminus <= 1'b0;
                        end else begin
`ifdef USB_TX_CRC16_EN
                            r_state <= S_CRC;
                            r_shift <= ~r_crc;
`else
                            r_state  <= S_EOP_SE0;
                            r_dplus  <= 1'b0;
                            r_dminus <= 1'b0;
`endif
                        end
                    end
                end
                S_EOP_SE0: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 4'd0) begin
                            r_bit_idx <= 4'd1;
                        end else begin
                            r_bit_idx <= '0;
                            r_state   <= S_EOP_J;
                            r_lvl     <= 1'b1;
                            r_dplus   <= 1'b1;
                            r_dminus  <= 1'b0;
                        end
                    end
                end
                S_EOP_J: begin
                    if (w_bit_end) begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_param.sv
// Directed bench for usb_tx_param: captures the D+/D- lines, NRZI-decodes and destuffs them,
// and compares packet bytes, EOP shape, packet length, pops and error pulses to hand-built expectations.
// Works for both builds: without on-chip CRC the bench places the CRC bytes in the FIFO itself.
module tb_usb_tx_param;

    localparam int CPB = 8;
`ifdef USB_TX_CRC16_EN
    localparam bit CRC_HW = 1'b1;
`else
    localparam bit CRC_HW = 1'b0;
`endif

    typedef logic [7:0] u8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [2:0] tx_packet = 3'd0;
    logic [7:0] tx_packet_data = 8'h00;
    logic [6:0] buffer_occupancy = 7'd0;
    logic       get_tx_packet_data;
    logic       tx_transfer_active;
    logic       tx_error;
    logic       dplus_out;
    logic       dminus_out;

    usb_tx_param #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(4), .OCC_W(7)) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_start           (tx_start),
        .tx_packet          (tx_packet),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .dplus_out          (dplus_out),
        .dminus_out         (dminus_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    u8          fifo_q[$];
    logic [1:0] cap_line [0:2047];
    logic       cap_act  [0:2047];
    int         cap_len, n_pop, n_err, last_pop, err_cyc;
    u8          dec_bytes[$];
    int         n_se0, n_jend, n_unstable, n_stufferr, n_act, n_leftover;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        buffer_occupancy = 7'(fifo_q.size());
        tx_packet_data   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // Shift-left CRC16 (x^15 in bit 15), data fed LSB first
    function automatic logic [15:0] crc_run(input u8 d[$], input int from);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = from; i < d.size(); i++) begin
            for (int j = 0; j < 8; j++) begin
                fb = d[i][j] ^ c[15];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        return c;
    endfunction

    // Bytes carrying the complemented CRC, highest-order bit first on the wire
    function automatic void crc_bytes(input u8 payload[$], output u8 b0, output u8 b1);
        logic [15:0] c;
        c = crc_run(payload, 0);
        for (int i = 0; i < 8; i++) begin
            b0[i] = ~c[15 - i];
            b1[i] = ~c[7 - i];
        end
    endfunction

    // Bit times on the wire for a byte stream, stuffed zeros included
    function automatic int stuffed_bits(input u8 d[$]);
        int total;
        int ones;
        total = 0;
        ones  = 0;
        for (int i = 0; i < d.size(); i++) begin
            for (int j = 0; j < 8; j++) begin
                total++;
                ones = d[i][j] ? ones + 1 : 0;
                if (ones == 6) begin
                    total++;
                    ones = 0;
                end
            end
        end
        return total;
    endfunction

    // Start a packet and record every cycle until tx_transfer_active falls (or an abort by reset)
    task automatic run_packet(input logic [2:0] code, input int abort_cyc);
        bit pend;
        bit seen;
        bit done;
        int n;
        pend = 0; seen = 0; done = 0; n = 0;
        n_pop = 0; n_err = 0; last_pop = -1; err_cyc = -1;
        @(negedge clk);
        drive_fifo();
        tx_packet = code;
        tx_start  = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        while (!done && n < 2048) begin
            if (pend) begin
                void'(fifo_q.pop_front());
                pend = 0;
            end
            drive_fifo();
            #1;
            cap_line[n] = {dplus_out, dminus_out};
            cap_act[n]  = tx_transfer_active;
            if (get_tx_packet_data) begin
                pend = 1; n_pop++; last_pop = n;
            end
            if (tx_error) begin
                n_err++; err_cyc = n;
            end
            if (tx_transfer_active) seen = 1;
            else if (seen) done = 1;
            if (n == abort_cyc) begin
                rst = 1'b1;
                @(negedge clk);
                #1;
                check("rst_lines", {dplus_out, dminus_out}, 2'b10);
                check("rst_active", tx_transfer_active, 0);
                check("rst_pop", get_tx_packet_data, 0);
                check("rst_err", tx_error, 0);
                rst  = 1'b0;
                done = 1;
            end
            n++;
            if (!done) @(negedge clk);
        end
        cap_len = n;
        check("pkt_ends", done, 1);
    endtask

    // NRZI decode with destuffing; sample each bit time mid-way and require a flat line within it
    task automatic decode();
        logic [1:0] prev;
        logic [1:0] sym;
        bit         b;
        bit         in_eop;
        int         ones;
        int         nbt;
        bit         bits_q[$];
        u8          cur;
        prev = 2'b10; ones = 0; in_eop = 0;
        n_se0 = 0; n_jend = 0; n_unstable = 0; n_stufferr = 0; n_act = 0;
        dec_bytes.delete();
        for (int c = 0; c < cap_len; c++) if (cap_act[c]) n_act++;
        nbt = (cap_len - 1) / CPB;
        for (int k = 0; k < nbt; k++) begin
            sym = cap_line[k*CPB + 4];
            for (int c = 0; c < CPB; c++) if (cap_line[k*CPB + c] !== sym) n_unstable++;
            if (sym == 2'b00) begin
                n_se0++;
                in_eop = 1;
            end else if (in_eop) begin
                if (sym == 2'b10) n_jend++;
            end else begin
                b    = (sym == prev);
                prev = sym;
                if (ones == 6) begin
                    if (b) n_stufferr++;
                    ones = 0;
                end else begin
                    bits_q.push_back(b);
                    ones = b ? ones + 1 : 0;
                end
            end
        end
        n_leftover = bits_q.size() % 8;
        for (int i = 0; i + 8 <= bits_q.size(); i += 8) begin
            for (int j = 0; j < 8; j++) cur[j] = bits_q[i + j];
            dec_bytes.push_back(cur);
        end
    endtask

    task automatic verify(input string nm, input u8 exp[$], input int exp_pop, input int exp_err);
        int nmin;
        decode();
        check({nm, "_nbytes"}, dec_bytes.size(), exp.size());
        check({nm, "_leftover"}, n_leftover, 0);
        nmin = (dec_bytes.size() < exp.size()) ? dec_bytes.size() : exp.size();
        for (int i = 0; i < nmin; i++) check($sformatf("%s_byte%0d", nm, i), dec_bytes[i], exp[i]);
        check({nm, "_se0_bits"}, n_se0, 2);
        check({nm, "_j_bits"}, n_jend, 1);
        check({nm, "_stable"}, n_unstable, 0);
        check({nm, "_stuff"}, n_stufferr, 0);
        check({nm, "_active_cyc"}, n_act, (stuffed_bits(exp) + 3) * CPB);
        check({nm, "_pops"}, n_pop, exp_pop);
        check({nm, "_errs"}, n_err, exp_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        u8 exp[$];
        u8 pay[$];
        u8 c0, c1;
        int bad_lines, act_hi, errs;

        drive_fifo();
        repeat (3) @(negedge clk);
        #1;
        check("reset_lines", {dplus_out, dminus_out}, 2'b10);
        check("reset_active", tx_transfer_active, 0);
        check("reset_err", tx_error, 0);
        check("reset_pop", get_tx_packet_data, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("idle_lines", {dplus_out, dminus_out}, 2'b10);
        check("idle_active", tx_transfer_active, 0);

        // ACK: 0x80, 0xD2, 19 bit times = 152 cycles
        fifo_q.delete();
        run_packet(3'd3, -1);
        exp = '{8'h80, 8'hD2};
        verify("ack", exp, 0, 0);
        check("ack_len152", n_act, 152);

        // STALL: PID 1110 -> 0x1E
        run_packet(3'd5, -1);
        exp = '{8'h80, 8'h1E};
        verify("stall", exp, 0, 0);

        // DATA0 zero length: CRC field is all zeros
        fifo_q.delete();
        if (!CRC_HW) fifo_q = '{8'h00, 8'h00};
        run_packet(3'd1, -1);
        exp = '{8'h80, 8'hC3, 8'h00, 8'h00};
        verify("d0_empty", exp, CRC_HW ? 0 : 2, 0);
        check("d0_empty_resid", crc_run(dec_bytes, 2), 16'h800D);

        // DATA1 {FF,FF}: stuffing inside the payload, CRC residual at the receiver
        pay = '{8'hFF, 8'hFF};
        crc_bytes(pay, c0, c1);
        fifo_q = pay;
        if (!CRC_HW) begin
            fifo_q.push_back(c0);
            fifo_q.push_back(c1);
        end
        run_packet(3'd2, -1);
        exp = '{8'h80, 8'h4B, 8'hFF, 8'hFF, c0, c1};
        verify("d1_ff", exp, CRC_HW ? 2 : 4, 0);
        check("d1_ff_resid", crc_run(dec_bytes, 2), 16'h800D);

        // Overflow with MAX_PAYLOAD=4: four pops, error, EOP with no CRC
        fifo_q.delete();
        for (int i = 1; i <= 10; i++) fifo_q.push_back(u8'(i));
        run_packet(3'd1, -1);
        exp = '{8'h80, 8'hC3, 8'h01, 8'h02, 8'h03, 8'h04};
        verify("ovf", exp, 4, 1);
        check("ovf_err_after_pop", (err_cyc > last_pop), 1);
        fifo_q.delete();
        drive_fifo();

        // Invalid code 6: one error pulse, bus stays idle
        @(negedge clk);
        tx_packet = 3'd6;
        tx_start  = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        bad_lines = 0; act_hi = 0; errs = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if ({dplus_out, dminus_out} != 2'b10) bad_lines++;
            if (tx_transfer_active) act_hi++;
            if (tx_error) errs++;
            @(negedge clk);
        end
        check("inv_err", errs, 1);
        check("inv_active", act_hi, 0);
        check("inv_lines", bad_lines, 0);

        // Reset in the middle of a DATA1 payload byte, then a clean ACK
        fifo_q = '{8'h11, 8'h22, 8'h33};
        run_packet(3'd2, 180);
        check("rst_one_pop", n_pop, 1);
        fifo_q.delete();
        drive_fifo();
        repeat (2) @(negedge clk);
        run_packet(3'd3, -1);
        exp = '{8'h80, 8'hD2};
        verify("ack2", exp, 0, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
